// File: rtl/seq_miter_checker.sv
// Windowed, clocked miter between gold and gate output buses with per-bit don't-care masking.
// Optional MITER_STOP_ON_FAIL_EN ends the window on the first failing sample.
module seq_miter_checker #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      clear,
  input  logic [CNT_W-1:0]          window,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_gold,
  input  logic [CHANNELS*WIDTH-1:0] in_gate,
  input  logic [CHANNELS*WIDTH-1:0] gold_def,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CHANNELS-1:0]       ch_fail,
  output logic [CH_W-1:0]           first_ch,
  output logic [CNT_W-1:0]          first_idx,
  output logic [CNT_W-1:0]          mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    window_q, window_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] ch_fail_q, ch_fail_d;
  logic [CH_W-1:0]     first_ch_q, first_ch_d;
  logic [CNT_W-1:0]    first_idx_q, first_idx_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;
  logic                done_q, done_d;

  logic [CHANNELS-1:0] ch_mis;
  logic [CH_W-1:0]     low_ch;
  logic                sample_fail;
  logic                last_sample;

  // Per-channel compare; the downward scan leaves the lowest failing index in low_ch.
  always_comb begin
    ch_mis = '0;
    low_ch = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_mis[c] = |(gold_def[c*WIDTH +: WIDTH] & (in_gold[c*WIDTH +: WIDTH] ^ in_gate[c*WIDTH +: WIDTH]));
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (ch_mis[c]) low_ch = CH_W'(c);
    end
  end

  assign sample_fail = |ch_mis;
  assign last_sample = (cnt_q == window_q - CNT_W'(1));

  // NOTE: every variable gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    cnt_d       = cnt_q;
    ch_fail_d   = ch_fail_q;
    first_ch_d  = first_ch_q;
    first_idx_d = first_idx_q;
    mcnt_d      = mcnt_q;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      cnt_d       = '0;
      ch_fail_d   = '0;
      first_ch_d  = '0;
      first_idx_d = '0;
      mcnt_d      = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            window_d    = window;
            cnt_d       = '0;
            ch_fail_d   = '0;
            first_ch_d  = '0;
            first_idx_d = '0;
            mcnt_d      = '0;
            if (window == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt_d     = cnt_q + CNT_W'(1);
            ch_fail_d = ch_fail_q | ch_mis;
            if (sample_fail) begin
              // First failure of the window is the only one that records position.
              if (~|ch_fail_q) begin
                first_ch_d  = low_ch;
                first_idx_d = cnt_q;
              end
              if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
            end
`ifdef MITER_STOP_ON_FAIL_EN
            if (last_sample || sample_fail) begin
`else
            if (last_sample) begin
`endif
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      window_q    <= '0;
      cnt_q       <= '0;
      ch_fail_q   <= '0;
      first_ch_q  <= '0;
      first_idx_q <= '0;
      mcnt_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      cnt_q       <= cnt_d;
      ch_fail_q   <= ch_fail_d;
      first_ch_q  <= first_ch_d;
      first_idx_q <= first_idx_d;
      mcnt_q      <= mcnt_d;
      done_q      <= done_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign pass         = (state_q == DONE) && ~|ch_fail_q;
  assign ch_fail      = ch_fail_q;
  assign first_ch     = first_ch_q;
  assign first_idx    = first_idx_q;
  assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_seq_miter_checker.sv
// Directed bench for seq_miter_checker: vector table plus hand-written multi-cycle sequences.
// Expectations follow MITER_STOP_ON_FAIL_EN when it is defined for the build.
module tb_seq_miter_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear, in_valid;
  logic [15:0] window;
  logic [31:0] in_gold, in_gate, gold_def;
  logic        busy, done, pass;
  logic [3:0]  ch_fail;
  logic [1:0]  first_ch;
  logic [15:0] first_idx, mismatch_cnt;

  logic        start_s, clear_s, in_valid_s;
  logic [3:0]  window_s;
  logic        busy_s, done_s, pass_s;
  logic [3:0]  ch_fail_s;
  logic [1:0]  first_ch_s;
  logic [3:0]  first_idx_s, mismatch_cnt_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_miter_checker #(.CHANNELS(4), .WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .window(window),
    .in_valid(in_valid), .in_gold(in_gold), .in_gate(in_gate), .gold_def(gold_def),
    .busy(busy), .done(done), .pass(pass), .ch_fail(ch_fail), .first_ch(first_ch),
    .first_idx(first_idx), .mismatch_cnt(mismatch_cnt)
  );

  seq_miter_checker #(.CHANNELS(4), .WIDTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .clear(clear_s), .window(window_s),
    .in_valid(in_valid_s), .in_gold(in_gold), .in_gate(in_gate), .gold_def(gold_def),
    .busy(busy_s), .done(done_s), .pass(pass_s), .ch_fail(ch_fail_s), .first_ch(first_ch_s),
    .first_idx(first_idx_s), .mismatch_cnt(mismatch_cnt_s)
  );

  typedef struct {
    logic        s, c;
    logic [15:0] w;
    logic        v;
    logic [31:0] g, t, d;
    logic        eb, ed, ep;
    logic [3:0]  ef;
    logic [15:0] ec;
    logic [1:0]  efc;
    logic [15:0] efi;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic c, input logic [15:0] w, input logic v,
                       input logic [31:0] g, input logic [31:0] t, input logic [31:0] d);
    start    = s;
    clear    = c;
    window   = w;
    in_valid = v;
    in_gold  = g;
    in_gate  = t;
    gold_def = d;
  endtask

  task automatic check_outs(input string tag, input logic b, input logic dn, input logic p,
                            input logic [3:0] f, input logic [15:0] cnt, input logic [1:0] fch,
                            input logic [15:0] fidx);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(dn));
    check({tag, ".pass"}, 32'(pass), 32'(p));
    check({tag, ".ch_fail"}, 32'(ch_fail), 32'(f));
    check({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(cnt));
    check({tag, ".first_ch"}, 32'(first_ch), 32'(fch));
    check({tag, ".first_idx"}, 32'(first_idx), 32'(fidx));
  endtask

  initial begin
    logic [31:0] g, m;
    int          samples;
    int          done_pulses;

    rst = 1'b1;
    start_s = 1'b0; clear_s = 1'b0; in_valid_s = 1'b0; window_s = '0;
    drive(0, 0, 16'd0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick; tick;
    check_outs("reset", 0, 0, 0, 4'h0, 16'd0, 2'd0, 16'd0);
    check("reset.sat_cnt", 32'(mismatch_cnt_s), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    check_outs("post_reset", 0, 0, 0, 4'h0, 16'd0, 2'd0, 16'd0);

    // Masked X, hold in DONE, clear, window=0, clear+start, start ignored in RUN, fully masked sample.
    //               s     c     w      v     gold          gate          def            busy  done  pass  ch_fail  cnt    fch   fidx
    vq.push_back('{1'b1, 1'b0, 16'd2, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b1, 32'h00FF_0000, 32'h0,       32'hFF00_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b0, 32'h00FF_0000, 32'h0,       32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b1, 32'h00FF_0000, 32'h0,       32'hFF01_FFFF, 1'b0, 1'b1, 1'b0, 4'b0100, 16'd1, 2'd2, 16'd1});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd1, 2'd2, 16'd1});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b1, 32'hFFFF_FFFF, 32'h0,       32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0100, 16'd1, 2'd2, 16'd1});
    vq.push_back('{1'b0, 1'b1, 16'd0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b1, 1'b0, 16'd0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b1, 1'b0, 16'd0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b1, 1'b1, 16'd5, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b1, 1'b0, 16'd3, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b1, 1'b0, 16'd1, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b0, 16'd0, 1'b1, 32'h0,        32'hFFFF_FFFF, 32'h0,        1'b0, 1'b1, 1'b1, 4'b0000, 16'd0, 2'd0, 16'd0});
    vq.push_back('{1'b0, 1'b1, 16'd0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0, 2'd0, 16'd0});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].s, vq[i].c, vq[i].w, vq[i].v, vq[i].g, vq[i].t, vq[i].d);
      tick;
      check_outs($sformatf("vec%0d", i), vq[i].eb, vq[i].ed, vq[i].ep, vq[i].ef, vq[i].ec, vq[i].efc, vq[i].efi);
    end

    // Clean run: 16 samples with in_valid on every other cycle.
    drive(1, 0, 16'd16, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick;
    check("clean.busy", 32'(busy), 32'd1);
    samples = 0;
    done_pulses = 0;
    for (int i = 0; i < 32; i++) begin
      g = $urandom;
      drive(0, 0, 16'd0, (i % 2) == 0, g, g, $urandom);
      tick;
      if ((i % 2) == 0) samples++;
      if (done) done_pulses++;
      check($sformatf("clean.done_c%0d", i), 32'(done), 32'((i % 2) == 0 && samples == 16));
    end
    check("clean.done_pulses", 32'(done_pulses), 32'd1);
    check_outs("clean.end", 0, 0, 1, 4'h0, 16'd0, 2'd0, 16'd0);
    drive(0, 1, 16'd0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick;

    // First-fail capture: sample 3 fails on ch3 and ch1, sample 7 on ch1.
    drive(1, 0, 16'd8, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick;
    for (int i = 0; i < 8; i++) begin
      g = $urandom;
      m = (i == 3) ? 32'h2000_0400 : (i == 7) ? 32'h0000_0100 : 32'h0;
      drive(0, 0, 16'd0, 1, g, g ^ m, 32'hFFFF_FFFF);
      tick;
      if (i == 3) begin
        check("ff.s3.ch_fail", 32'(ch_fail), 32'hA);
        check("ff.s3.first_ch", 32'(first_ch), 32'd1);
        check("ff.s3.first_idx", 32'(first_idx), 32'd3);
        check("ff.s3.cnt", 32'(mismatch_cnt), 32'd1);
`ifdef MITER_STOP_ON_FAIL_EN
        check("ff.s3.done", 32'(done), 32'd1);
        check("ff.s3.busy", 32'(busy), 32'd0);
`else
        check("ff.s3.done", 32'(done), 32'd0);
        check("ff.s3.busy", 32'(busy), 32'd1);
`endif
      end
`ifndef MITER_STOP_ON_FAIL_EN
      if (i == 7) check("ff.s7.done", 32'(done), 32'd1);
`endif
    end
`ifdef MITER_STOP_ON_FAIL_EN
    check_outs("ff.end", 0, 0, 0, 4'hA, 16'd1, 2'd1, 16'd3);
`else
    check_outs("ff.end", 0, 1, 0, 4'hA, 16'd2, 2'd1, 16'd3);
`endif
    drive(0, 1, 16'd0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick;
    check_outs("ff.clear", 0, 0, 0, 4'h0, 16'd0, 2'd0, 16'd0);

    // Saturation instance, CNT_W=4: 15 failing samples in a window of 15.
    drive(0, 0, 16'd0, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    start_s = 1'b1; window_s = 4'hF;
    tick;
    start_s = 1'b0;
    for (int i = 0; i < 15; i++) begin
      g = $urandom;
      in_gold = g; in_gate = ~g; gold_def = 32'hFFFF_FFFF;
      in_valid_s = 1'b1;
      tick;
`ifdef MITER_STOP_ON_FAIL_EN
      if (i == 0) check("sat.done_first", 32'(done_s), 32'd1);
`else
      check($sformatf("sat.cnt_s%0d", i), 32'(mismatch_cnt_s), 32'(i + 1));
      if (i == 14) check("sat.done_last", 32'(done_s), 32'd1);
`endif
    end
    in_valid_s = 1'b0;
    tick;
`ifdef MITER_STOP_ON_FAIL_EN
    check("sat.final_cnt", 32'(mismatch_cnt_s), 32'd1);
`else
    check("sat.final_cnt", 32'(mismatch_cnt_s), 32'd15);
`endif
    check("sat.first_idx", 32'(first_idx_s), 32'd0);
    check("sat.ch_fail", 32'(ch_fail_s), 32'hF);
    check("sat.pass", 32'(pass_s), 32'd0);
    check("main.idle_during_sat", 32'(busy), 32'd0);

    // Reset mid-window after 5 of 10 samples.
    drive(1, 0, 16'd10, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick;
    for (int i = 0; i < 5; i++) begin
      g = $urandom;
`ifdef MITER_STOP_ON_FAIL_EN
      m = 32'h0;
`else
      m = (i == 2) ? 32'h0000_0001 : 32'h0;
`endif
      drive(0, 0, 16'd0, 1, g, g ^ m, 32'hFFFF_FFFF);
      tick;
    end
    check("rstmid.busy_before", 32'(busy), 32'd1);
`ifndef MITER_STOP_ON_FAIL_EN
    check("rstmid.fail_before", 32'(ch_fail), 32'h1);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("rstmid.async", 0, 0, 0, 4'h0, 16'd0, 2'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("rstmid.no_done%0d", i), 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 16'd4, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    tick;
    check("rstmid.restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      g = $urandom;
      drive(0, 0, 16'd0, 1, g, g, 32'hFFFF_FFFF);
      tick;
    end
    check_outs("rstmid.clean", 0, 1, 1, 4'h0, 16'd0, 2'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_miter_checker.md
# seq_miter_checker

Synthesizable, parametrised sequential miter checker for gate-level equivalence runs on the AES ASAP7 flow. It compares CHANNELS gold/gate output buses, each WIDTH bits, over a programmable window of valid samples. Don't-care gold bits are masked per bit. It reports a sticky per-channel fail vector, the first failing channel and sample index, and a saturating mismatch count. It sits between the gold and gate instances of a partition testbench, replacing the purely combinational per-partition compare with a windowed, clocked check usable in simulation and on emulation hardware.

## Interface
- CHANNELS, default 4: number of compared buses.
- WIDTH, default 8: bits per bus.
- CNT_W, default 16: width of the window, sample-index and mismatch counters.
- CH_W, derived: max(1, $clog2(CHANNELS)).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a check window; sampled only in IDLE or DONE.
- clear  in  1  synchronous clear of all results; returns to IDLE.
- window  in  CNT_W  number of valid samples to compare; latched on start.
- in_valid  in  1  current in_gold/in_gate/gold_def are a sample.
- in_gold  in  CHANNELS*WIDTH  gold outputs; channel c occupies bits [c*WIDTH +: WIDTH].
- in_gate  in  CHANNELS*WIDTH  gate outputs; same packing.
- gold_def  in  CHANNELS*WIDTH  1 = gold bit defined; 0 = don't care, never a mismatch.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  high in DONE when no mismatch was recorded.
- ch_fail  out  CHANNELS  sticky per-channel mismatch flags.
- first_ch  out  CH_W  lowest-index failing channel of the first failing sample.
- first_idx  out  CNT_W  sample index (0-based) of the first failing sample.
- mismatch_cnt  out  CNT_W  failing samples counted; saturates at all-ones.

## Operation
- Channel c mismatches on a sample when |(gold_def_c & (in_gold_c ^ in_gate_c)). A sample fails if any channel mismatches.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start latches window. If window==0, go to DONE. Otherwise clear the sample counter and results, then go to RUN.
  - RUN: each in_valid cycle increments the sample counter and updates the results. When the accepted sample is number window-1, go to DONE.
  - DONE: results held. start restarts the window exactly as from IDLE, clearing results. clear goes to IDLE.
- start while in RUN is ignored.
- clear has priority over start and over sample acceptance in every state. It zeroes ch_fail, first_ch, first_idx, mismatch_cnt and the sample counter.
- first_ch and first_idx are written only on the first failing sample of a window and frozen afterwards.
- mismatch_cnt saturates at 2^CNT_W-1 and never wraps. The sample counter cannot wrap, because window ≤ 2^CNT_W-1.
- pass = (state==DONE) && ~|ch_fail. It is 0 outside DONE. A window of 0 gives pass=1.
- Inputs are ignored when in_valid=0, and in IDLE or DONE.

## Timing
- A sample accepted at edge N is reflected in ch_fail, first_*, and mismatch_cnt after edge N. Latency is 1 cycle.
- The last sample at edge N: state becomes DONE and done=1 in the cycle after edge N. The results include that sample in the same cycle.
- start at edge N: busy=1 from the cycle after edge N. For window==0, done pulses in the cycle after edge N.
- Reset values: state IDLE; busy, done, pass 0; ch_fail 0; first_ch 0; first_idx 0; mismatch_cnt 0.
- rst asserted mid-window aborts immediately to the reset values. No done pulse is issued.
- There is no backpressure: every in_valid sample in RUN is consumed.

## Configuration
- MITER_STOP_ON_FAIL_EN defined: in RUN, the first failing sample causes the transition to DONE on that edge, with done pulsing the next cycle. mismatch_cnt is then 1, and later samples are not compared.
- MITER_STOP_ON_FAIL_EN undefined: the window always runs to completion, and mismatch_cnt counts every failing sample.

## Test plan
- Clean run: CHANNELS=4, WIDTH=8, window=16, 16 valid samples with gold==gate, in_valid toggling 50%. Required: done pulses once after the 16th sample, pass=1, ch_fail=0, mismatch_cnt=0.
- Masked X: gold=0xFF, gate=0x00 on ch2, gold_def ch2=0x00. Required: no mismatch. Then set gold_def ch2=0x01. Required: ch_fail=4'b0100.
- First-fail capture: samples 3 and 7 fail on ch3 and ch1, and sample 3 also fails on ch1. Required (macro off): first_ch=1, first_idx=3, ch_fail=4'b1010, mismatch_cnt=2, pass=0.
- Early stop (macro on): same stimulus as the first-fail capture. Required: DONE one cycle after sample 3, mismatch_cnt=1, first_idx=3.
- Boundaries: window=0 gives done the next cycle with pass=1. start in RUN is ignored. clear together with start in DONE goes to IDLE with all results 0. CNT_W=4 with 15 failing samples gives mismatch_cnt=15 with no wrap.
- Reset mid-window: assert rst after 5 of 10 samples. Required: all outputs return to 0 asynchronously, with no done pulse. A following start runs a clean window.
